// File: rtl/johnson_pkg.sv
// rtl/johnson_pkg.sv - shared state encodings and Johnson step/phase helpers
package johnson_pkg;

  // Widest counter the helpers support; callers zero-extend into this width.
  localparam int JW_MAX = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } seq_state_t;

  function automatic logic [JW_MAX-1:0] johnson_next(input logic [JW_MAX-1:0] q,
                                                     input int n);
    logic [JW_MAX-1:0] r;
    logic              msb;
    msb = 1'b0;
    for (int i = 0; i < JW_MAX; i++) begin
      if (i == n - 1) msb = q[i];
    end
    r = '0;
    for (int i = 0; i < JW_MAX; i++) begin
      if (i == 0) r[i] = ~msb;
      else if (i < n) r[i] = q[i-1];
    end
    return r;
  endfunction

  // Legal codes are a run of ones anchored at bit 0 or at bit n-1; anything else decodes to 0.
  function automatic logic [2*JW_MAX-1:0] johnson_phase(input logic [JW_MAX-1:0] q,
                                                        input int n);
    logic [2*JW_MAX-1:0] r;
    logic [JW_MAX-1:0]   low_m;
    logic [JW_MAX-1:0]   high_m;
    logic                msb;
    int                  p;
    int                  k;
    p   = 0;
    msb = 1'b0;
    for (int i = 0; i < JW_MAX; i++) begin
      if (i < n && q[i]) p = p + 1;
      if (i == n - 1) msb = q[i];
    end
    for (int i = 0; i < JW_MAX; i++) begin
      low_m[i]  = (i < p);
      high_m[i] = (i >= n - p) && (i < n);
    end
    k = msb ? (2 * n - p) : p;
    r = '0;
    if (q == low_m || q == high_m) begin
      for (int i = 0; i < 2 * JW_MAX; i++) r[i] = (i == k);
    end
    return r;
  endfunction

endpackage

// File: rtl/johnson_core.sv
// rtl/johnson_core.sv - N-bit Johnson counter register with clear and enable
module johnson_core
  import johnson_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  output logic [N-1:0] q
);

  logic [N-1:0]      q_q;
  logic [N-1:0]      q_d;
  logic [JW_MAX-1:0] q_ext;
  logic [JW_MAX-1:0] q_nxt;

  always_comb begin
    q_ext         = '0;
    q_ext[N-1:0]  = q_q;
    q_nxt         = johnson_next(q_ext, N);
    q_d           = q_q;
    if (clear) q_d = '0;
    else if (enable) q_d = q_nxt[N-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/johnson_step_sequencer.sv
// rtl/johnson_step_sequencer.sv - runs a Johnson counter for a programmed step count
module johnson_step_sequencer
  import johnson_pkg::*;
#(
  parameter int N     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] num_steps,
  input  logic             pause,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [N-1:0]     johnson_q,
  output logic [2*N-1:0]   phase,
  output logic [CNT_W-1:0] remaining
);

  seq_state_t          state_q, state_d;
  logic [CNT_W-1:0]    remaining_q, remaining_d;
  logic                clear, step;
  logic [JW_MAX-1:0]   q_ext;
  logic [2*JW_MAX-1:0] phase_full;

  johnson_core #(.N(N)) u_core (
    .clk    (clk),
    .reset  (reset),
    .clear  (clear),
    .enable (step),
    .q      (johnson_q)
  );

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    clear       = 1'b0;
    step        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (num_steps != '0) begin
            state_d     = ST_RUN;
            remaining_d = num_steps;
            clear       = 1'b1;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d     = ST_IDLE;
          remaining_d = '0;
        end else if (pause) begin
          state_d = ST_HOLD;
        end else begin
          // remaining is at least 1 in RUN, so the decrement cannot wrap.
          step        = 1'b1;
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == CNT_W'(1)) state_d = ST_DONE;
        end
      end
      ST_HOLD: begin
        if (abort) begin
          state_d     = ST_IDLE;
          remaining_d = '0;
        end else if (!pause) begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
    end
  end

  always_comb begin
    q_ext        = '0;
    q_ext[N-1:0] = johnson_q;
    phase_full   = johnson_phase(q_ext, N);
    phase        = phase_full[2*N-1:0];
  end

  assign busy      = (state_q == ST_RUN) || (state_q == ST_HOLD);
  assign done      = (state_q == ST_DONE);
  assign remaining = remaining_q;

endmodule

// File: tb/tb_johnson_step_sequencer.sv
// tb/tb_johnson_step_sequencer.sv - directed self-checking bench for johnson_step_sequencer
module tb_johnson_step_sequencer;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] num_steps;
  logic       pause;
  logic       abort;
  logic       busy;
  logic       done;
  logic [3:0] johnson_q;
  logic [7:0] phase;
  logic [7:0] remaining;

  int n_cmp;
  int n_fail;

  johnson_step_sequencer #(.N(4), .CNT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .num_steps (num_steps),
    .pause     (pause),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .johnson_q (johnson_q),
    .phase     (phase),
    .remaining (remaining)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; num_steps = '0; pause = 1'b0; abort = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done got %b want 0", done); end
    n_cmp++; if (johnson_q !== 4'b0000) begin n_fail++; $display("FAIL rst_q got %b want 0000", johnson_q); end
    n_cmp++; if (phase !== 8'h01) begin n_fail++; $display("FAIL rst_phase got %b want 00000001", phase); end
    n_cmp++; if (remaining !== 8'd0) begin n_fail++; $display("FAIL rst_rem got %0d want 0", remaining); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_idle_busy got %b want 0", busy); end
  endtask

  task automatic test_basic_run();
    logic [3:0] exp_q [5];
    exp_q = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110};
    start = 1'b1; num_steps = 8'd5;
    tick();
    start = 1'b0;
    n_cmp++; if (busy !== 1'b1 || johnson_q !== 4'b0000 || remaining !== 8'd5) begin
      n_fail++; $display("FAIL t1_accept busy=%b q=%b rem=%0d want 1/0000/5", busy, johnson_q, remaining);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++; if (johnson_q !== exp_q[i]) begin n_fail++; $display("FAIL t1_q step %0d got %b want %b", i + 1, johnson_q, exp_q[i]); end
      n_cmp++; if (remaining !== 8'(4 - i)) begin n_fail++; $display("FAIL t1_rem step %0d got %0d want %0d", i + 1, remaining, 4 - i); end
      n_cmp++; if (busy !== (i < 4)) begin n_fail++; $display("FAIL t1_busy step %0d got %b want %b", i + 1, busy, (i < 4)); end
      n_cmp++; if (done !== (i == 4)) begin n_fail++; $display("FAIL t1_done step %0d got %b want %b", i + 1, done, (i == 4)); end
    end
    n_cmp++; if (phase !== 8'b0010_0000) begin n_fail++; $display("FAIL t1_phase got %b want 00100000", phase); end
    tick();
    n_cmp++; if (done !== 1'b0 || busy !== 1'b0 || johnson_q !== 4'b1110) begin
      n_fail++; $display("FAIL t1_idle done=%b busy=%b q=%b want 0/0/1110", done, busy, johnson_q);
    end
  endtask

  task automatic test_wrap();
    int done_cnt;
    done_cnt = 0;
    start = 1'b1; num_steps = 8'd8;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done) done_cnt++;
    end
    n_cmp++; if (johnson_q !== 4'b0000) begin n_fail++; $display("FAIL t2_q got %b want 0000", johnson_q); end
    n_cmp++; if (phase !== 8'b0000_0001) begin n_fail++; $display("FAIL t2_phase got %b want 00000001", phase); end
    n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL t2_done got %b want 1", done); end
    n_cmp++; if (remaining !== 8'd0) begin n_fail++; $display("FAIL t2_rem got %0d want 0", remaining); end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done) done_cnt++;
    end
    n_cmp++; if (done_cnt != 1) begin n_fail++; $display("FAIL t2_done_count got %0d want 1", done_cnt); end
  endtask

  task automatic test_pause();
    int cyc;
    start = 1'b1; num_steps = 8'd5;
    tick();
    start = 1'b0;
    tick(); tick();
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (johnson_q !== 4'b0011 || busy !== 1'b1) begin
        n_fail++; $display("FAIL t3_hold cyc %0d q=%b busy=%b want 0011/1", i, johnson_q, busy);
      end
    end
    n_cmp++; if (phase !== 8'b0000_0100 || remaining !== 8'd3) begin
      n_fail++; $display("FAIL t3_hold_phase phase=%b rem=%0d want 00000100/3", phase, remaining);
    end
    pause = 1'b0;
    cyc = 0;
    while (cyc < 20 && done !== 1'b1) begin
      tick();
      cyc++;
    end
    n_cmp++; if (cyc != 4) begin n_fail++; $display("FAIL t3_latency got %0d cycles want 4", cyc); end
    n_cmp++; if (johnson_q !== 4'b1110) begin n_fail++; $display("FAIL t3_final_q got %b want 1110", johnson_q); end
    tick();
  endtask

  task automatic test_abort();
    int done_cnt;
    done_cnt = 0;
    start = 1'b1; num_steps = 8'd6;
    tick();
    start = 1'b0;
    tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL t4_idle busy=%b done=%b want 0/0", busy, done); end
    n_cmp++; if (johnson_q !== 4'b0011) begin n_fail++; $display("FAIL t4_q_held got %b want 0011", johnson_q); end
    n_cmp++; if (remaining !== 8'd0) begin n_fail++; $display("FAIL t4_rem got %0d want 0", remaining); end
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done) done_cnt++;
    end
    n_cmp++; if (done_cnt != 0) begin n_fail++; $display("FAIL t4_no_done got %0d pulses want 0", done_cnt); end
    start = 1'b1; num_steps = 8'd3;
    tick();
    start = 1'b0;
    n_cmp++; if (johnson_q !== 4'b0000 || busy !== 1'b1 || remaining !== 8'd3) begin
      n_fail++; $display("FAIL t4_restart q=%b busy=%b rem=%0d want 0000/1/3", johnson_q, busy, remaining);
    end
    tick(); tick(); tick();
    n_cmp++; if (done !== 1'b1 || johnson_q !== 4'b0111) begin
      n_fail++; $display("FAIL t4_restart_done done=%b q=%b want 1/0111", done, johnson_q);
    end
    tick();
  endtask

  task automatic test_zero_and_ignore();
    int cyc;
    start = 1'b1; num_steps = 8'd0;
    tick();
    start = 1'b0;
    n_cmp++; if (done !== 1'b1 || busy !== 1'b0 || johnson_q !== 4'b0111) begin
      n_fail++; $display("FAIL t5_zero done=%b busy=%b q=%b want 1/0/0111", done, busy, johnson_q);
    end
    tick();
    n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL t5_zero_after done=%b busy=%b want 0/0", done, busy); end
    start = 1'b1; num_steps = 8'd4;
    tick();
    num_steps = 8'd7;
    tick(); tick();
    start = 1'b0;
    cyc = 0;
    while (cyc < 20 && done !== 1'b1) begin
      tick();
      cyc++;
    end
    n_cmp++; if (cyc != 2) begin n_fail++; $display("FAIL t5_ignore_busy got %0d extra cycles want 2", cyc); end
    n_cmp++; if (johnson_q !== 4'b1111) begin n_fail++; $display("FAIL t5_ignore_q got %b want 1111", johnson_q); end
    start = 1'b1; num_steps = 8'd2;
    tick();
    start = 1'b0;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || remaining !== 8'd0) begin
      n_fail++; $display("FAIL t5_ignore_done busy=%b done=%b rem=%0d want 0/0/0", busy, done, remaining);
    end
    tick();
  endtask

  task automatic test_reset_midrun();
    int done_cnt;
    done_cnt = 0;
    start = 1'b1; num_steps = 8'd5;
    tick();
    start = 1'b0;
    tick(); tick();
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (johnson_q !== 4'b0000 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL t6_async q=%b busy=%b done=%b want 0000/0/0", johnson_q, busy, done);
    end
    n_cmp++; if (phase !== 8'h01 || remaining !== 8'd0) begin
      n_fail++; $display("FAIL t6_async_phase phase=%b rem=%0d want 00000001/0", phase, remaining);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done || busy) done_cnt++;
    end
    n_cmp++; if (done_cnt != 0 || johnson_q !== 4'b0000) begin
      n_fail++; $display("FAIL t6_release active_cycles=%0d q=%b want 0/0000", done_cnt, johnson_q);
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_basic_run();
    test_wrap();
    test_pause();
    test_abort();
    test_zero_and_ignore();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
